// File: rtl/seq_gen_if.sv
// Switch-style bus between the sequence generator and whoever observes it.
// master drives start/mode and watches the codes; slave is the generator.
interface seq_gen_if;
    logic       start;
    logic [1:0] mode;
    logic [3:0] sw_out;
    logic       busy;
    logic       done;
    logic [2:0] step;
    logic [1:0] led;

    modport master (
        output start, mode,
        input  sw_out, busy, done, step, led
    );

    modport slave (
        input  start, mode,
        output sw_out, busy, done, step, led
    );
endinterface

// File: rtl/seq_gen.sv
// Scripted one-hot code transmitter for the switch-sequence detector, with a
// parallel model of the detector state shown on the LEDs.
module seq_gen #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    seq_gen_if.slave   bus
);

    localparam int unsigned STEP_W = 3;
    localparam int unsigned CODE_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] LED_S0 = 2'b01;
    localparam logic [1:0] LED_S1 = 2'b10;
    localparam logic [1:0] LED_S2 = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q,  step_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [1:0]        mode_q,  mode_d;
    logic [1:0]        led_q,   led_d;
    logic [CODE_W-1:0] sw_out_q, sw_out_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [CODE_W-1:0] cur_code;
    logic              hold_end;
    logic              gap_end;
    logic              is_last;

    // Code table: all scripts share a 0001,0010 prefix.
    function automatic logic [CODE_W-1:0] code_of(input logic [1:0] m,
                                                  input logic [STEP_W-1:0] s);
        logic [CODE_W-1:0] c;
        c = '0;
        case (s)
            3'd0:    c = 4'b0001;
            3'd1:    c = 4'b0010;
            3'd2:    c = (m == 2'd2) ? 4'b1000 : 4'b0100;
            3'd3:    c = 4'b0010;
            3'd4:    c = 4'b1000;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [STEP_W-1:0] last_of(input logic [1:0] m);
        logic [STEP_W-1:0] l;
        l = '0;
        case (m)
            2'd0:    l = 3'd1;
            2'd1:    l = 3'd3;
            2'd2:    l = 3'd2;
            default: l = 3'd4;
        endcase
        return l;
    endfunction

    // Detector transition rules; unlisted code/state pairs hold.
    function automatic logic [1:0] led_next(input logic [1:0] s,
                                            input logic [CODE_W-1:0] c);
        logic [1:0] n;
        n = s;
        case (s)
            LED_S0:  if (c == 4'b0001) n = LED_S1;
            LED_S1:  if (c == 4'b0010) n = LED_S2;
            LED_S2:  begin
                if (c == 4'b0100)      n = LED_S1;
                else if (c == 4'b1000) n = LED_S0;
            end
            default: n = s;
        endcase
        return n;
    endfunction

    assign cur_code = code_of(mode_q, step_q);
    assign hold_end = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign gap_end  = (cnt_q == CNT_W'(GAP_CYCLES - 1));
    assign is_last  = (step_q == last_of(mode_q));

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        led_d   = led_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    step_d  = '0;
                    cnt_d   = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) led_d = led_next(led_q, cur_code);
                if (hold_end) begin
                    cnt_d = '0;
                    if (is_last) begin
                        state_d = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        step_d = step_q + STEP_W'(1);
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_end) begin
                    cnt_d   = '0;
                    step_d  = step_q + STEP_W'(1);
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sw_out_d = (state_d == DRIVE) ? code_of(mode_d, step_d) : '0;
        busy_d   = (state_d == DRIVE) || (state_d == GAP);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= '0;
            led_q    <= LED_S0;
            sw_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            led_q    <= led_d;
            sw_out_q <= sw_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.sw_out = sw_out_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.step   = step_q;
    assign bus.led    = led_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: expected per-cycle outputs are queued when a
// script is started and popped against the DUT on each falling edge.
module tb_seq_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_gen_if bus_a ();
    seq_gen_if bus_b ();

    seq_gen #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    seq_gen #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct packed {
        logic [3:0] sw;
        logic       busy;
        logic       done;
        logic [2:0] step;
        logic [1:0] led;
    } obs_t;

    typedef struct {
        obs_t v;
        bit   chk_step;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] led_a;
    logic [1:0] led_b;

    function automatic obs_t mk(input logic [3:0] sw, input logic busy,
                                input logic done, input logic [2:0] step,
                                input logic [1:0] led);
        obs_t o;
        o.sw = sw; o.busy = busy; o.done = done; o.step = step; o.led = led;
        return o;
    endfunction

    function automatic obs_t sample(input bit which);
        if (which)
            return mk(bus_b.sw_out, bus_b.busy, bus_b.done, bus_b.step, bus_b.led);
        return mk(bus_a.sw_out, bus_a.busy, bus_a.done, bus_a.step, bus_a.led);
    endfunction

    function automatic logic [1:0] led_rule(input logic [1:0] s, input logic [3:0] c);
        if (s == 2'b01 && c == 4'b0001) return 2'b10;
        if (s == 2'b10 && c == 4'b0010) return 2'b11;
        if (s == 2'b11 && c == 4'b0100) return 2'b10;
        if (s == 2'b11 && c == 4'b1000) return 2'b01;
        return s;
    endfunction

    task automatic drive(input bit which, input logic s, input logic [1:0] m);
        if (which) begin
            bus_b.start = s; bus_b.mode = m;
        end else begin
            bus_a.start = s; bus_a.mode = m;
        end
    endtask

    task automatic compare(input bit which, input exp_t e, input string tag, input int cyc);
        obs_t o;
        o = sample(which);
        if (!e.chk_step) o.step = e.v.step;
        vectors++;
        assert (o === e.v) else begin
            miscompares++;
            $error("FAIL %s cyc%0d: got sw=%b busy=%b done=%b step=%0d led=%b, expected sw=%b busy=%b done=%b step=%0d led=%b",
                   tag, cyc, o.sw, o.busy, o.done, o.step, o.led,
                   e.v.sw, e.v.busy, e.v.done, e.v.step, e.v.led);
        end
    endtask

    task automatic check_reset(input bit which, input string tag);
        exp_t e;
        e.v = mk(4'b0000, 1'b0, 1'b0, 3'd0, 2'b01);
        e.chk_step = 1'b1;
        compare(which, e, tag, 0);
    endtask

    task automatic check_idle(input bit which, input logic [1:0] led, input string tag);
        exp_t e;
        @(negedge clk);
        e.v = mk(4'b0000, 1'b0, 1'b0, 3'd0, led);
        e.chk_step = 1'b0;
        compare(which, e, tag, 0);
    endtask

    // Expand a script into its cycle-by-cycle expected outputs.
    task automatic push_script(input int m, input int hold, input int gap,
                               inout logic [1:0] led, output int len);
        logic [3:0] codes[$];
        exp_t       e;
        case (m)
            0:       codes = '{4'b0001, 4'b0010};
            1:       codes = '{4'b0001, 4'b0010, 4'b0100, 4'b0010};
            2:       codes = '{4'b0001, 4'b0010, 4'b1000};
            default: codes = '{4'b0001, 4'b0010, 4'b0100, 4'b0010, 4'b1000};
        endcase
        len = codes.size();
        e.chk_step = 1'b1;
        for (int k = 0; k < len; k++) begin
            for (int h = 0; h < hold; h++) begin
                e.v = mk(codes[k], 1'b1, 1'b0, 3'(k), led);
                exp_q.push_back(e);
                if (h == 0) led = led_rule(led, codes[k]);
            end
            if (k < len - 1) begin
                for (int g = 0; g < gap; g++) begin
                    e.v = mk(4'b0000, 1'b1, 1'b0, 3'(k), led);
                    exp_q.push_back(e);
                end
            end
        end
        e.v = mk(4'b0000, 1'b0, 1'b1, 3'd0, led);
        e.chk_step = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic run_script(input bit which, input int m, input int hold, input int gap,
                              input bit held, input int abort_at, input string tag,
                              inout logic [1:0] led);
        int   len;
        int   lat;
        int   cyc;
        int   done_cyc;
        exp_t e;
        obs_t o;
        check_idle(which, led, {tag, "_pre_idle"});
        drive(which, 1'b1, 2'(m));
        push_script(m, hold, gap, led, len);
        lat = len * hold + (len - 1) * gap + 1;
        cyc = 0;
        done_cyc = -1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            if (held) drive(which, 1'b1, 2'($urandom_range(3)));
            else      drive(which, 1'b0, 2'(m));
            e = exp_q.pop_front();
            compare(which, e, tag, cyc);
            o = sample(which);
            if (o.done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (cyc == abort_at) begin
                rst = 1'b1;
                exp_q.delete();
            end
        end
        if (abort_at == 0) begin
            vectors++;
            assert (done_cyc == lat) else begin
                miscompares++;
                $error("FAIL %s_latency: got %0d cycles, expected %0d", tag, done_cyc, lat);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 2'd0);
        repeat (3) @(negedge clk);
        check_reset(1'b0, "reset_a");
        check_reset(1'b1, "reset_b");
        rst = 1'b0;
        led_a = 2'b01;
        led_b = 2'b01;

        run_script(1'b0, 0, 4, 2, 1'b0, 0, "mode0", led_a);
        run_script(1'b0, 0, 4, 2, 1'b0, 0, "mode0_again", led_a);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset(1'b0, "reset_between");
        rst = 1'b0;
        led_a = 2'b01;
        run_script(1'b0, 3, 4, 2, 1'b0, 0, "mode3", led_a);

        run_script(1'b0, 1, 4, 2, 1'b1, 0, "held_start", led_a);
        check_idle(1'b0, led_a, "held_after_done");
        drive(1'b0, 1'b0, 2'd0);
        check_idle(1'b0, led_a, "held_no_rerun");

        run_script(1'b0, 1, 4, 2, 1'b0, 6, "mode1_rst", led_a);
        @(negedge clk);
        check_reset(1'b0, "rst_mid_gap");
        rst = 1'b0;
        led_a = 2'b01;
        run_script(1'b0, 0, 4, 2, 1'b0, 0, "after_rst", led_a);

        run_script(1'b1, 2, 1, 0, 1'b0, 0, "nogap_mode2", led_b);
        check_idle(1'b1, led_b, "nogap_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
